// File: rtl/soc_evt_arbiter.sv
// rtl/soc_evt_arbiter.sv - round-robin arbiter of SoC peripheral event pulses into one event-ID stream
// Optional overflow counter: define SOC_EVT_ARB_OVF_CNT_EN; otherwise overflow_cnt_o is tied to 0.
module soc_evt_arbiter #(
  parameter int NB_SRC     = 32,
  parameter int EVNT_WIDTH = 8,
  parameter int ID_BASE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_SRC-1:0]     evt_pulse_i,
  input  logic [NB_SRC-1:0]     src_mask_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic [NB_SRC-1:0]     pending_o,
  output logic                  overflow_o,
  output logic [15:0]           overflow_cnt_o
);

  localparam int                    PTR_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam logic [PTR_W:0]        NB_W   = (PTR_W+1)'(NB_SRC);
  localparam logic [EVNT_WIDTH-1:0] BASE_W = EVNT_WIDTH'(ID_BASE);

  if ((64'(ID_BASE) + 64'(NB_SRC)) > (64'(1) << EVNT_WIDTH)) begin : g_id_range_chk
    $error("soc_evt_arbiter: ID_BASE+NB_SRC exceeds 2**EVNT_WIDTH");
  end

  logic [NB_SRC-1:0]     r_pend;
  logic                  r_valid;
  logic [EVNT_WIDTH-1:0] r_data;
  logic [PTR_W-1:0]      r_ptr;
  logic                  r_ovf;

  logic [NB_SRC-1:0]     w_set;
  logic [NB_SRC-1:0]     w_clr;
  logic [NB_SRC-1:0]     w_lost;
  logic [NB_SRC-1:0]     w_pend_nxt;
  logic                  w_load;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W:0]        w_idx;
  logic [PTR_W-1:0]      w_ptr_nxt;

  assign w_set  = evt_pulse_i & src_mask_i;
  assign w_load = ~r_valid | evt_ready_i;

  // Scan from the farthest offset down so the nearest pending index at/after r_ptr wins last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = NB_SRC - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= NB_W) begin
        w_idx = w_idx - NB_W;
      end
      if (r_pend[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_load && w_found) begin
      w_clr[w_win] = 1'b1;
    end
  end

  assign w_ptr_nxt  = ({1'b0, w_win} == (NB_W - 1'b1)) ? '0 : (w_win + 1'b1);
  assign w_lost     = w_set & r_pend & ~w_clr;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= |w_lost;
      if (w_load) begin
        if (w_found) begin
          r_valid <= 1'b1;
          r_data  <= BASE_W + EVNT_WIDTH'(w_win);
          r_ptr   <= w_ptr_nxt;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SOC_EVT_ARB_OVF_CNT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_nlost;
  logic [16:0] w_cnt_sum;

  // Several sources may lose an event in the same cycle; add them all, then saturate.
  always_comb begin
    w_nlost = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      w_nlost = w_nlost + 16'(w_lost[i]);
    end
    w_cnt_sum = {1'b0, r_cnt} + {1'b0, w_nlost};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_cnt_sum[16]) begin
      r_cnt <= 16'hFFFF;
    end else begin
      r_cnt <= w_cnt_sum[15:0];
    end
  end

  assign overflow_cnt_o = r_cnt;
`else
  assign overflow_cnt_o = '0;
`endif

  assign evt_valid_o = r_valid;
  assign evt_data_o  = r_data;
  assign pending_o   = r_pend;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_soc_evt_arbiter.sv
// tb/tb_soc_evt_arbiter.sv - self-checking bench for soc_evt_arbiter (vector table + ID scoreboard)
module tb_soc_evt_arbiter;

`ifdef SOC_EVT_ARB_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] evt_pulse_i;
  logic [31:0] src_mask_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [7:0]  evt_data_o;
  logic [31:0] pending_o;
  logic        overflow_o;
  logic [15:0] overflow_cnt_o;

  soc_evt_arbiter #(.NB_SRC(32), .EVNT_WIDTH(8), .ID_BASE(0)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .evt_pulse_i    (evt_pulse_i),
    .src_mask_i     (src_mask_i),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_data_o     (evt_data_o),
    .pending_o      (pending_o),
    .overflow_o     (overflow_o),
    .overflow_cnt_o (overflow_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [31:0] pulse;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [31:0] exp_pend;
    int          npush;
    logic [7:0]  p0, p1, p2;
  } vec_t;

  vec_t       vecs[21];
  logic [7:0] sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  bit         sb_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ecnt(input int v);
    if (!CNT_EN) return 16'h0;
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic rdy,
                              input logic ev, input logic [7:0] ed, input logic [31:0] ep,
                              input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.pulse = p; v.ready = rdy; v.exp_valid = ev; v.exp_data = ed; v.exp_pend = ep;
    v.npush = n; v.p0 = a; v.p1 = b; v.p2 = c;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [31:0] p, input logic rdy);
    rst_i       = r;
    evt_pulse_i = p;
    evt_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [7:0] d,
                         input logic [31:0] pd, input logic ov);
    chk({nm, "_valid"}, 32'(evt_valid_o), 32'(v));
    if (v) chk({nm, "_data"}, 32'(evt_data_o), 32'(d));
    chk({nm, "_pend"}, pending_o, pd);
    chk({nm, "_ovf"}, 32'(overflow_o), 32'(ov));
  endtask

  // Handshake happens at the next posedge; inputs for that edge are already driven here.
  always @(negedge clk_i) begin
    if (sb_on && !rst_i && evt_valid_o && evt_ready_i) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_beat: got id 0x%0h expected no beat (t=%0t)", evt_data_o, $time);
      end else begin
        chk("sb_id", 32'(evt_data_o), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    vecs[0]  = mk(0, 32'h0000_0020, 1, 0, 8'd0, 32'h0000_0020, 1, 8'd5, 8'd0, 8'd0);
    vecs[1]  = mk(0, 32'h0,         1, 1, 8'd5, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[2]  = mk(0, 32'h0,         1, 0, 8'd5, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[3]  = mk(1, 32'h0,         1, 0, 8'd0, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[4]  = mk(0, 32'h0000_008A, 1, 0, 8'd0, 32'h0000_008A, 3, 8'd1, 8'd3, 8'd7);
    vecs[5]  = mk(0, 32'h0,         1, 1, 8'd1, 32'h0000_0088, 0, 8'd0, 8'd0, 8'd0);
    vecs[6]  = mk(0, 32'h0,         1, 1, 8'd3, 32'h0000_0080, 0, 8'd0, 8'd0, 8'd0);
    vecs[7]  = mk(0, 32'h0,         1, 1, 8'd7, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[8]  = mk(0, 32'h0000_0208, 1, 0, 8'd7, 32'h0000_0208, 2, 8'd9, 8'd3, 8'd0);
    vecs[9]  = mk(0, 32'h0,         1, 1, 8'd9, 32'h0000_0008, 0, 8'd0, 8'd0, 8'd0);
    vecs[10] = mk(0, 32'h0,         1, 1, 8'd3, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[11] = mk(0, 32'h0,         1, 0, 8'd3, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[12] = mk(0, 32'h0000_0004, 0, 0, 8'd3, 32'h0000_0004, 1, 8'd2, 8'd0, 8'd0);
    vecs[13] = mk(0, 32'h0000_0001, 0, 1, 8'd2, 32'h0000_0001, 1, 8'd0, 8'd0, 8'd0);
    for (int i = 14; i <= 18; i++)
      vecs[i] = mk(0, 32'h0, 0, 1, 8'd2, 32'h0000_0001, 0, 8'd0, 8'd0, 8'd0);
    vecs[19] = mk(0, 32'h0,         1, 1, 8'd0, 32'h0,         0, 8'd0, 8'd0, 8'd0);
    vecs[20] = mk(0, 32'h0,         1, 0, 8'd0, 32'h0,         0, 8'd0, 8'd0, 8'd0);

    src_mask_i = 32'hFFFF_FFFF;
    cyc(1, 32'h0, 1);
    cyc(1, 32'h0, 1);
    chk("rst_valid", 32'(evt_valid_o), 32'h0);
    chk("rst_data", 32'(evt_data_o), 32'h0);
    chk("rst_pend", pending_o, 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    chk("rst_cnt", 32'(overflow_cnt_o), 32'h0);
    sb_on = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].npush > 0) sb_q.push_back(vecs[i].p0);
      if (vecs[i].npush > 1) sb_q.push_back(vecs[i].p1);
      if (vecs[i].npush > 2) sb_q.push_back(vecs[i].p2);
      cyc(vecs[i].rst, vecs[i].pulse, vecs[i].ready);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_pend, 1'b0);
    end

    // Loss on a source that is already pending while the slot is held.
    sb_q.push_back(8'd10);
    cyc(0, 32'h0000_0400, 0); chk_out("ovf_c1", 0, 8'd0,  32'h0000_0400, 0);
    sb_q.push_back(8'd4);
    cyc(0, 32'h0000_0010, 0); chk_out("ovf_c2", 1, 8'd10, 32'h0000_0010, 0);
    cyc(0, 32'h0000_0010, 0); chk_out("ovf_c3", 1, 8'd10, 32'h0000_0010, 1);
    exp_cnt = 1;
    chk("ovf_cnt1", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));
    cyc(0, 32'h0, 0);         chk_out("ovf_c4", 1, 8'd10, 32'h0000_0010, 0);
    chk("ovf_cnt1_hold", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));
    cyc(0, 32'h0, 1);         chk_out("ovf_c5", 1, 8'd4,  32'h0, 0);
    cyc(0, 32'h0, 1);         chk_out("ovf_c6", 0, 8'd4,  32'h0, 0);

    // Re-pulse in the same cycle the source is loaded: kept, not lost.
    sb_q.push_back(8'd6);
    cyc(0, 32'h0000_0040, 1); chk_out("rel_d1", 0, 8'd4, 32'h0000_0040, 0);
    sb_q.push_back(8'd6);
    cyc(0, 32'h0000_0040, 1); chk_out("rel_d2", 1, 8'd6, 32'h0000_0040, 0);
    cyc(0, 32'h0, 1);         chk_out("rel_d3", 1, 8'd6, 32'h0, 0);
    cyc(0, 32'h0, 1);         chk_out("rel_d4", 0, 8'd6, 32'h0, 0);
    chk("rel_cnt", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));

    // Saturation: hold the slot, then lose events on sources 8..31 until the count is near the top.
    cyc(0, 32'hFFFF_FFFF, 0); chk_out("sat_e1", 0, 8'd6, 32'hFFFF_FFFF, 0);
    cyc(0, 32'h0, 0);         chk_out("sat_e2", 1, 8'd7, 32'hFFFF_FF7F, 0);
    while (exp_cnt + 24 <= 32'hFFFE) begin
      cyc(0, 32'hFFFF_FF00, 0);
      exp_cnt += 24;
    end
    chk("sat_ovf_bulk", 32'(overflow_o), 32'h1);
    if (exp_cnt < 32'hFFFE) begin
      cyc(0, ((32'h1 << (32'hFFFE - exp_cnt)) - 32'h1) << 8, 0);
      exp_cnt = 32'hFFFE;
    end
    chk("sat_cnt_fffe", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));
    cyc(0, 32'h0000_0700, 0);
    exp_cnt += 3;
    chk_out("sat_three", 1, 8'd7, 32'hFFFF_FF7F, 1);
    chk("sat_cnt_ffff", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));
    cyc(0, 32'h0, 0);         chk_out("sat_after", 1, 8'd7, 32'hFFFF_FF7F, 0);
    chk("sat_cnt_stay", 32'(overflow_cnt_o), 32'(ecnt(exp_cnt)));

    // Reset mid-transfer drops the held beat and all pending events.
    cyc(1, 32'h0, 0);
    chk_out("mid_rst", 0, 8'd0, 32'h0, 0);
    chk("mid_rst_data", 32'(evt_data_o), 32'h0);
    chk("mid_rst_cnt", 32'(overflow_cnt_o), 32'h0);
    cyc(0, 32'h0, 1);         chk_out("post_rst", 0, 8'd0, 32'h0, 0);

    // Masked source: dropped silently.
    src_mask_i = ~32'h0000_1000;
    cyc(0, 32'h0000_1000, 1); chk_out("mask_a", 0, 8'd0, 32'h0, 0);
    cyc(0, 32'h0000_1000, 1); chk_out("mask_b", 0, 8'd0, 32'h0, 0);
    cyc(0, 32'h0, 1);         chk_out("mask_c", 0, 8'd0, 32'h0, 0);
    chk("mask_cnt", 32'(overflow_cnt_o), 32'h0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
